// File: rtl/babbage_pkg.sv
// Shared definitions for the Babbage difference-engine emulator blocks.
// Default widths and the binary-to-BCD converter state encoding.
package babbage_pkg;

    localparam int unsigned W_DEFAULT      = 20;
    localparam int unsigned DIGITS_DEFAULT = 7;
    localparam int unsigned CW_DEFAULT     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } bin2bcd_state_t;

endpackage

// File: rtl/babbage_bin2bcd_adj3.sv
// Double-dabble digit cell: adds 3 to a BCD nibble whose value is 5 or more.
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din > 4'd4)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/babbage_bin2bcd.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3) with a held result
// register feeding the seven-segment display multiplexer.
module babbage_bin2bcd
    import babbage_pkg::*;
#(
    parameter int unsigned W      = W_DEFAULT,
    parameter int unsigned DIGITS = DIGITS_DEFAULT,
    parameter int unsigned CW     = CW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BW = 4 * DIGITS;

    bin2bcd_state_t state, state_next;
    logic [W-1:0]   sreg, sreg_next;
    logic [BW-1:0]  wbcd, wbcd_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [BW-1:0]  bcd_reg, bcd_next;
    logic [BW-1:0]  adj;
    logic [BW+W-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (wbcd[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign shifted = {adj, sreg} << 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            sreg    <= '0;
            wbcd    <= '0;
            cnt     <= '0;
            bcd_reg <= '0;
        end else begin
            state   <= state_next;
            sreg    <= sreg_next;
            wbcd    <= wbcd_next;
            cnt     <= cnt_next;
            bcd_reg <= bcd_next;
        end
    end

    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        wbcd_next  = wbcd;
        cnt_next   = cnt;
        bcd_next   = bcd_reg;
        ready      = 1'b0;
        done_tick  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    sreg_next  = bin;
                    wbcd_next  = '0;
                    cnt_next   = CW'(W);
                    state_next = OP;
                end
            end
            OP: begin
                wbcd_next = shifted[BW+W-1:W];
                sreg_next = shifted[W-1:0];
                cnt_next  = cnt - 1'b1;
                // The final shift is loaded straight into bcd so it is valid with done_tick.
                if (cnt == CW'(1)) begin
                    bcd_next   = shifted[BW+W-1:W];
                    state_next = DONE;
                end
            end
            DONE: begin
                done_tick  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bcd = bcd_reg;

endmodule
